x25519_field_unit: RTL and testbench

- Shared arithmetic datapath for one X25519 Montgomery-ladder step. It holds three independent engines, each with its own enable and one-cycle valid pulse:
  - a modular adder;
  - an iterative modular multiplier;
  - a conditional swap (select).
- All arithmetic is modulo p = 2^255 − 19. A microcoded sequencer drives the block and stores results in its temporary registers.

---
 rtl/x25519_field_unit_if.sv | 41 ++++
 rtl/x25519_field_unit.sv | 165 ++++++++++++++++
 tb/tb_x25519_field_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x25519_field_unit_if.sv
// Operand/result bundle for the X25519 field unit.
// Three independent enable/valid channels: add, mult, select.
interface x25519_field_unit_if #(
  parameter int WIDTH = 264
);
  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_valid;
  logic [WIDTH-1:0] add_out;
  logic             mult_en;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             mult_valid;
  logic [WIDTH-1:0] mult_out;
  logic             sel_en;
  logic             sel_b;
  logic [511:0]     sel_r;
  logic [511:0]     sel_s;
  logic             sel_valid;
  logic [511:0]     sel_p;
  logic [511:0]     sel_q;

  modport master (
    output add_en, add_a, add_b,
    output mult_en, mult_a, mult_b,
    output sel_en, sel_b, sel_r, sel_s,
    input  add_valid, add_out,
    input  mult_valid, mult_out,
    input  sel_valid, sel_p, sel_q
  );

  modport slave (
    input  add_en, add_a, add_b,
    input  mult_en, mult_a, mult_b,
    input  sel_en, sel_b, sel_r, sel_s,
    output add_valid, add_out,
    output mult_valid, mult_out,
    output sel_valid, sel_p, sel_q
  );
endinterface

// File: rtl/x25519_field_unit.sv
// X25519 ladder-step datapath: mod-p adder, iterative
// mod-p multiplier and constant-time conditional swap.
module x25519_field_unit #(
  parameter int WIDTH = 264
) (
  input logic              clk,
  input logic              rst,
  x25519_field_unit_if.slave bus
);

  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  // 2^255 == 19 (mod p); two folds leave a value below 2p
  function automatic logic [255:0] fold(input logic [WIDTH:0] s);
    logic [255:0] x;
    logic [255:0] y;
    x = {1'b0, s[254:0]} + 256'(s[WIDTH:255]) * 256'd19;
    y = {1'b0, x[254:0]} + (x[255] ? 256'd19 : 256'd0);
    return y;
  endfunction

  function automatic logic [255:0] csub(input logic [255:0] x);
    return (x >= P) ? (x - P) : x;
  endfunction

  // ---------------- adder ----------------
  logic [WIDTH:0]   r_add_s;
  logic [255:0]     r_add_x;
  logic             r_add_v1;
  logic             r_add_v2;
  logic             r_add_valid;
  logic [WIDTH-1:0] r_add_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_add_s     <= '0;
      r_add_x     <= '0;
      r_add_v1    <= 1'b0;
      r_add_v2    <= 1'b0;
      r_add_valid <= 1'b0;
      r_add_out   <= '0;
    end else begin
      r_add_s     <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
      r_add_v1    <= bus.add_en;
      r_add_x     <= fold(r_add_s);
      r_add_v2    <= r_add_v1;
      r_add_valid <= r_add_v2;
      if (r_add_v2)
        r_add_out <= {{(WIDTH-256){1'b0}}, csub(r_add_x)};
    end
  end

  // ---------------- multiplier ----------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_done;
  logic [255:0]     r_ma;
  logic [WIDTH-1:0] r_mb;
  logic [255:0]     r_acc;
  logic [8:0]       r_cnt;
  logic             r_mult_valid;
  logic [WIDTH-1:0] r_mult_out;
  logic [255:0]     w_dbl;
  logic [255:0]     w_sum;
  logic [255:0]     w_acc_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mult_en) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == 9'd0)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // acc < p always, so doubling and adding a stay below 2p
  always_comb begin
    w_dbl     = csub({r_acc[254:0], 1'b0});
    w_sum     = csub(w_dbl + r_ma);
    w_acc_nxt = r_mb[WIDTH-1] ? w_sum : w_dbl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ma         <= '0;
      r_mb         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mult_valid <= 1'b0;
      r_mult_out   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mult_valid <= w_done;
      if (w_load) begin
        r_ma  <= csub(fold({1'b0, bus.mult_a}));
        r_mb  <= bus.mult_b;
        r_acc <= '0;
        r_cnt <= 9'(WIDTH - 1);
      end
      if (w_step) begin
        r_acc <= w_acc_nxt;
        r_mb  <= {r_mb[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt - 9'd1;
      end
      if (w_done)
        r_mult_out <= {{(WIDTH-256){1'b0}}, r_acc};
    end
  end

  // ---------------- select ----------------
  logic [511:0] w_t;
  logic         r_sel_valid;
  logic [511:0] r_sel_p;
  logic [511:0] r_sel_q;

  assign w_t = {512{bus.sel_b}} & (bus.sel_r ^ bus.sel_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_valid <= 1'b0;
      r_sel_p     <= '0;
      r_sel_q     <= '0;
    end else begin
      r_sel_valid <= bus.sel_en;
      if (bus.sel_en) begin
        r_sel_p <= bus.sel_r ^ w_t;
        r_sel_q <= bus.sel_s ^ w_t;
      end
    end
  end

  assign bus.add_valid  = r_add_valid;
  assign bus.add_out    = r_add_out;
  assign bus.mult_valid = r_mult_valid;
  assign bus.mult_out   = r_mult_out;
  assign bus.sel_valid  = r_sel_valid;
  assign bus.sel_p      = r_sel_p;
  assign bus.sel_q      = r_sel_q;

endmodule

// File: tb/tb_x25519_field_unit.sv
// Directed bench for x25519_field_unit: adder, multiplier,
// select, busy/reset behaviour and concurrency.
module tb_x25519_field_unit;

  localparam logic [263:0] P = (264'd1 << 255) - 264'd19;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  x25519_field_unit_if #(.WIDTH(264)) bus ();

  x25519_field_unit #(.WIDTH(264)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.add_valid, bus.mult_valid, bus.sel_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids got %b exp 000",
        {bus.add_valid, bus.mult_valid, bus.sel_valid});
    end
    checks++;
    if ((bus.add_out | bus.mult_out) !== 264'd0) begin
      errors++;
      $display("FAIL reset_add_mult_out got %h %h exp 0",
        bus.add_out, bus.mult_out);
    end
    checks++;
    if ((bus.sel_p | bus.sel_q) !== 512'd0) begin
      errors++;
      $display("FAIL reset_sel_out got nonzero");
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_single(input logic [263:0] a,
                                 input logic [263:0] b,
                                 input logic [263:0] exp);
    bus.add_a  = a;
    bus.add_b  = b;
    bus.add_en = 1'b1;
    tick();
    bus.add_en = 1'b0;
    checks++;
    if (bus.add_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early1 got %b exp 0", bus.add_valid);
    end
    tick();
    checks++;
    if (bus.add_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early2 got %b exp 0", bus.add_valid);
    end
    tick();
    checks++;
    if (bus.add_valid !== 1'b1 || bus.add_out !== exp) begin
      errors++;
      $display("FAIL add_result valid %b got %h exp %h",
        bus.add_valid, bus.add_out, exp);
    end
    tick();
    checks++;
    if (bus.add_valid !== 1'b0 || bus.add_out !== exp) begin
      errors++;
      $display("FAIL add_hold valid %b got %h exp %h",
        bus.add_valid, bus.add_out, exp);
    end
  endtask

  task automatic test_add_pipe();
    logic [263:0] va [3];
    logic [263:0] vb [3];
    logic [263:0] ve [3];
    va[0] = 264'd1; vb[0] = 264'd2; ve[0] = 264'd3;
    va[1] = 264'd3; vb[1] = 264'd4; ve[1] = 264'd7;
    va[2] = P;      vb[2] = 264'd0; ve[2] = 264'd0;
    for (int i = 0; i < 3; i++) begin
      bus.add_a  = va[i];
      bus.add_b  = vb[i];
      bus.add_en = 1'b1;
      tick();
    end
    bus.add_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.add_valid !== 1'b1 || bus.add_out !== ve[i]) begin
        errors++;
        $display("FAIL add_pipe%0d valid %b got %h exp %h",
          i, bus.add_valid, bus.add_out, ve[i]);
      end
      tick();
    end
    checks++;
    if (bus.add_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_pipe_end valid %b exp 0", bus.add_valid);
    end
  endtask

  task automatic test_mult(input logic [263:0] a,
                           input logic [263:0] b,
                           input logic [263:0] exp);
    int cnt;
    bus.mult_a  = a;
    bus.mult_b  = b;
    bus.mult_en = 1'b1;
    tick();
    bus.mult_en = 1'b0;
    cnt = 1;
    while (bus.mult_valid !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 266) begin
      errors++;
      $display("FAIL mult_latency got %0d exp 266", cnt);
    end
    checks++;
    if (bus.mult_out !== exp) begin
      errors++;
      $display("FAIL mult_value got %h exp %h", bus.mult_out, exp);
    end
    tick();
    checks++;
    if (bus.mult_valid !== 1'b0) begin
      errors++;
      $display("FAIL mult_pulse got %b exp 0", bus.mult_valid);
    end
  endtask

  task automatic test_mult_busy();
    int pulses;
    int first;
    logic [263:0] val;
    pulses = 0;
    first  = 0;
    val    = '0;
    bus.mult_a  = 264'd3;
    bus.mult_b  = 264'd5;
    bus.mult_en = 1'b1;
    tick();
    bus.mult_en = 1'b0;
    for (int c = 2; c <= 600; c++) begin
      bus.mult_en = (c == 50);
      bus.mult_a  = 264'd7;
      bus.mult_b  = 264'd7;
      tick();
      if (bus.mult_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          first = c;
          val   = bus.mult_out;
        end
      end
    end
    bus.mult_en = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL mult_busy_pulses got %0d exp 1", pulses);
    end
    checks++;
    if (first != 266 || val !== 264'd15) begin
      errors++;
      $display("FAIL mult_busy_first cyc %0d val %h exp 266 f",
        first, val);
    end
  endtask

  task automatic test_mult_reset();
    int pulses;
    pulses = 0;
    bus.mult_a  = 264'd121665;
    bus.mult_b  = 264'd2;
    bus.mult_en = 1'b1;
    tick();
    bus.mult_en = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (bus.mult_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mult_reset_pulses got %0d exp 0", pulses);
    end
    checks++;
    if (bus.mult_out !== 264'd0) begin
      errors++;
      $display("FAIL mult_reset_out got %h exp 0", bus.mult_out);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bus.mult_a  = 264'd9;
    bus.mult_b  = 264'd9;
    bus.mult_en = 1'b1;
    tick();
    bus.mult_en = 1'b0;
    cnt = 1;
    while (bus.mult_valid !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    checks++;
    if (bus.mult_valid !== 1'b1 || bus.mult_out !== 264'd81) begin
      errors++;
      $display("FAIL b2b_first valid %b got %h exp 51",
        bus.mult_valid, bus.mult_out);
    end
    bus.mult_a  = 264'd5;
    bus.mult_b  = 264'd6;
    bus.mult_en = 1'b1;
    tick();
    bus.mult_en = 1'b0;
    cnt = 1;
    while (bus.mult_valid !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 266 || bus.mult_out !== 264'd30) begin
      errors++;
      $display("FAIL b2b_second cyc %0d got %h exp 266 1e",
        cnt, bus.mult_out);
    end
  endtask

  task automatic test_select();
    logic [511:0] r;
    logic [511:0] s;
    r = {128{4'h1}};
    s = {128{4'h2}};
    for (int b = 0; b < 2; b++) begin
      bus.sel_r  = r;
      bus.sel_s  = s;
      bus.sel_b  = b[0];
      bus.sel_en = 1'b1;
      tick();
      bus.sel_en = 1'b0;
      bus.sel_r  = '0;
      bus.sel_s  = '0;
      checks++;
      if (bus.sel_valid !== 1'b1) begin
        errors++;
        $display("FAIL sel_valid%0d got %b exp 1", b, bus.sel_valid);
      end
      checks++;
      if (bus.sel_p !== (b ? s : r) || bus.sel_q !== (b ? r : s)) begin
        errors++;
        $display("FAIL sel_data%0d p %h q %h", b, bus.sel_p, bus.sel_q);
      end
      tick();
      checks++;
      if (bus.sel_valid !== 1'b0) begin
        errors++;
        $display("FAIL sel_pulse%0d got %b exp 0", b, bus.sel_valid);
      end
    end
  endtask

  task automatic test_concurrency();
    bus.add_a  = 264'd5;
    bus.add_b  = 264'd6;
    bus.add_en = 1'b1;
    bus.sel_r  = {128{4'hA}};
    bus.sel_s  = {128{4'h5}};
    bus.sel_b  = 1'b1;
    bus.sel_en = 1'b1;
    tick();
    bus.add_en = 1'b0;
    bus.sel_en = 1'b0;
    checks++;
    if (bus.sel_valid !== 1'b1 || bus.add_valid !== 1'b0
        || bus.sel_p !== {128{4'h5}} || bus.sel_q !== {128{4'hA}}) begin
      errors++;
      $display("FAIL conc_sel sv %b av %b", bus.sel_valid, bus.add_valid);
    end
    tick();
    tick();
    checks++;
    if (bus.add_valid !== 1'b1 || bus.add_out !== 264'd11) begin
      errors++;
      $display("FAIL conc_add valid %b got %h exp b",
        bus.add_valid, bus.add_out);
    end
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.add_en  = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.mult_en = 1'b0;
    bus.mult_a  = '0;
    bus.mult_b  = '0;
    bus.sel_en  = 1'b0;
    bus.sel_b   = 1'b0;
    bus.sel_r   = '0;
    bus.sel_s   = '0;
    test_reset();
    test_add_single(P - 264'd1, 264'd2, 264'd1);
    test_add_single({264{1'b1}}, 264'd0, 264'd9727);
    test_add_pipe();
    test_mult(264'd121665, 264'd2, 264'd243330);
    test_mult(P - 264'd1, P - 264'd1, 264'd1);
    test_mult(264'd1 << 255, 264'd1, 264'd19);
    test_mult_busy();
    test_back_to_back();
    test_mult_reset();
    test_select();
    test_concurrency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
